// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for two writeback requesters onto one register-file write port
// Ports: clk, reset (sync, active-high), hold (stall), req_valid/req_reg0/1/req_data0/1 (requests),
//   req_ready (combinational one-hot grant), wr_en/wr_addr/wr_data/wr_dec (registered write port), prio (debug).
// Optional: ZERO_REG_SUPPRESS_EN drops the registered write to register NUM_REGS-1 while still accepting it.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_reg0,
  input  logic [ADDR_WIDTH-1:0] req_reg1,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [DATA_WIDTH-1:0] req_data1,
  output logic [1:0]            req_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]   wr_dec,
  output logic                  prio
);
`ifdef ZERO_REG_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif
  logic                  prio_q, prio_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]   wr_dec_q, wr_dec_d;
  logic                  fire, gsel;
  logic [ADDR_WIDTH-1:0] gaddr;
  logic [DATA_WIDTH-1:0] gdata;
  always_comb begin
    req_ready = (reset || hold) ? 2'b00
              : (req_valid == 2'b11) ? (prio_q ? 2'b10 : 2'b01)
              : req_valid;
    fire      = |(req_valid & req_ready);
    gsel      = req_ready[1];
    gaddr     = gsel ? req_reg1 : req_reg0;
    gdata     = gsel ? req_data1 : req_data0;
    prio_d    = fire ? ~gsel : prio_q;
    // an accepted write to the last register can be swallowed here without disturbing the handshake
    wr_en_d   = fire && !(SUPPRESS && gaddr == ADDR_WIDTH'(NUM_REGS-1));
    wr_addr_d = wr_en_d ? gaddr : wr_addr_q;
    wr_data_d = wr_en_d ? gdata : wr_data_q;
    wr_dec_d  = wr_en_d ? (NUM_REGS'(1) << gaddr) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_dec_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_dec_q  <= wr_dec_d;
    end
  end
  assign prio    = prio_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_dec  = wr_dec_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [4:0]  req_reg0 = '0, req_reg1 = '0;
  logic [63:0] req_data0 = '0, req_data1 = '0;
  logic [1:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] wr_dec;
  logic        prio;
  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
    logic [31:0] dec;
  } wr_t;
  wr_t q[$];
  int checks = 0;
  int fails = 0;
  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_reg0(req_reg0), .req_reg1(req_reg1), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dec(wr_dec), .prio(prio)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic rs, input logic h, input logic [1:0] v,
                     input logic [4:0] a0, input logic [63:0] d0,
                     input logic [4:0] a1, input logic [63:0] d1,
                     input logic [1:0] er, input logic ep, input logic een);
    wr_t e;
    logic [31:0] one;
    one = 32'h1;
    reset = rs; hold = h; req_valid = v;
    req_reg0 = a0; req_data0 = d0; req_reg1 = a1; req_data1 = d1;
    #1;
    chk("req_ready", {62'b0, req_ready}, {62'b0, er});
    chk("prio", {63'b0, prio}, {63'b0, ep});
    @(posedge clk);
    #1;
    chk("wr_en", {63'b0, wr_en}, {63'b0, een});
    if (een) begin
      e.addr = er[1] ? a1 : a0;
      e.data = er[1] ? d1 : d0;
      e.dec  = one << e.addr;
      q.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    if (wr_en) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h with empty queue", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", {59'b0, wr_addr}, {59'b0, e.addr});
        chk("wr_data", wr_data, e.data);
        chk("wr_dec", {32'b0, wr_dec}, {32'b0, e.dec});
      end
    end else if (!reset) begin
      chk("wr_dec_idle", {32'b0, wr_dec}, 64'h0);
    end
  end
  initial begin
    @(posedge clk);
    #1;
    // reset held with both requesting
    cyc(1, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b00, 0, 0);
    cyc(1, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b00, 0, 0);
    chk("wr_addr_rst", {59'b0, wr_addr}, 64'h0);
    chk("wr_data_rst", wr_data, 64'h0);
    chk("wr_dec_rst", {32'b0, wr_dec}, 64'h0);
    // dual contention from reset: 0,1,0,1
    cyc(0, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b01, 0, 1);
    cyc(0, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b10, 1, 1);
    cyc(0, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b01, 0, 1);
    cyc(0, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b10, 1, 1);
    // single requester
    cyc(0, 0, 2'b01, 5'd5, 64'hDEAD, 5'd2, 64'h22, 2'b01, 0, 1);
    chk("wr_dec_r5", {32'b0, wr_dec}, 64'h20);
    // hold three cycles, prio frozen at 1
    cyc(0, 1, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b00, 1, 0);
    cyc(0, 1, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b00, 1, 0);
    cyc(0, 1, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b00, 1, 0);
    cyc(0, 0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 2'b10, 1, 1);
    // bring prio to 1, then same-register conflict
    cyc(0, 0, 2'b01, 5'd3, 64'h33, 5'd2, 64'h22, 2'b01, 0, 1);
    cyc(0, 0, 2'b11, 5'd7, 64'h1, 5'd7, 64'h2, 2'b10, 1, 1);
    cyc(0, 0, 2'b01, 5'd7, 64'h1, 5'd7, 64'h2, 2'b01, 0, 1);
    chk("last_write_wins", wr_data, 64'h1);
    // last register
`ifdef ZERO_REG_SUPPRESS_EN
    cyc(0, 0, 2'b01, 5'd31, 64'h5A, 5'd2, 64'h22, 2'b01, 1, 0);
    chk("xzr_addr_hold", {59'b0, wr_addr}, 64'd7);
    chk("xzr_data_hold", wr_data, 64'h1);
    chk("xzr_dec", {32'b0, wr_dec}, 64'h0);
`else
    cyc(0, 0, 2'b01, 5'd31, 64'h5A, 5'd2, 64'h22, 2'b01, 1, 1);
    chk("xzr_dec", {32'b0, wr_dec}, 64'h80000000);
`endif
    chk("prio_after_r31", {63'b0, prio}, 64'h1);
    // reset mid-stream blocks the transfer
    cyc(1, 0, 2'b11, 5'd4, 64'h44, 5'd6, 64'h66, 2'b00, 1, 0);
    chk("prio_post_rst", {63'b0, prio}, 64'h0);
    cyc(0, 0, 2'b11, 5'd4, 64'h44, 5'd6, 64'h66, 2'b01, 0, 1);
    cyc(0, 0, 2'b00, 5'd4, 64'h44, 5'd6, 64'h66, 2'b00, 1, 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates two writeback requesters (0 = ALU result, 1 = memory load) onto the single register-file write port.
- Accepts at most one write per cycle using round-robin priority.
- Registers the winning write and drives the one-hot per-register write enables (wr_dec) consumed by the register-file decode tree.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_WIDTH, 64: width of write data.
- ADDR_WIDTH, 5: register address width.
- NUM_REGS, 32: number of registers; equals 2**ADDR_WIDTH and is the width of wr_dec.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- hold  input  1  Pipeline stall; while high no request is accepted.
- req_valid  input  2  Per-requester write request.
- req_reg0  input  ADDR_WIDTH  Destination register, requester 0.
- req_reg1  input  ADDR_WIDTH  Destination register, requester 1.
- req_data0  input  DATA_WIDTH  Write data, requester 0.
- req_data1  input  DATA_WIDTH  Write data, requester 1.
- req_ready  output  2  Per-requester accept. Combinational, one-hot or zero.
- wr_en  output  1  Registered write strobe to the register file.
- wr_addr  output  ADDR_WIDTH  Registered write address.
- wr_data  output  DATA_WIDTH  Registered write data.
- wr_dec  output  NUM_REGS  Registered one-hot decode of wr_addr, gated by wr_en.
- prio  output  1  Current round-robin priority holder (debug).

Behaviour:
- Handshake:
  - A transfer occurs for requester i when req_valid[i] and req_ready[i] are both high in the same cycle.
  - A requester holds valid, reg and data stable until accepted.
  - valid must not depend on ready.
- Ready generation (combinational):
  - All ready = 0 if reset or hold.
  - Otherwise, if only one requester is valid, it gets ready.
  - If both are valid, ready goes to the requester equal to prio.
  - At most one bit of req_ready is high in any cycle.
- Priority update:
  - On a transfer from requester i, prio <= ~i at the next edge.
  - With no transfer, prio is unchanged.
  - prio resets to 0.
- Write stage (1-cycle latency):
  - On a transfer, at the next edge: wr_en <= 1, wr_addr <= granted reg, wr_data <= granted data, wr_dec <= 1 << granted reg.
  - With no transfer: wr_en <= 0 and wr_dec <= 0; wr_addr and wr_data hold their previous values.
  - Throughput is one write per cycle. Back-to-back grants produce a continuous wr_en.
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, wr_dec = 0, prio = 0.
- Boundary conditions:
  - Reset mid-operation: reset takes priority over any transfer in the same cycle. That transfer is not accepted (ready = 0), so the requester keeps its request.
  - Hold: no grant and prio frozen. wr_en drops the cycle after hold rises, and grants resume the cycle hold falls.
  - Both requesters targeting the same register: still serialized, winner first. The loser's write follows in the next cycle, so the last write wins.
  - Continuous dual requests alternate 0,1,0,1... from reset; starvation is impossible.

Optional Feature:
- Macro: ZERO_REG_SUPPRESS_EN.
- Defined: a transfer whose destination is register NUM_REGS-1 (X31/XZR) is still accepted (ready asserted, prio updated). The registered stage, however, produces wr_en = 0 and wr_dec = 0 for that cycle. wr_addr and wr_data hold their previous values.
- Not defined: register NUM_REGS-1 is written like any other register.

Test Plan:
- Reset behaviour: assert reset for 2 cycles with req_valid = 2'b11 -> req_ready = 00 throughout; wr_en = 0, wr_dec = 0, prio = 0 after reset.
- Single requester: req_valid = 01, req_reg0 = 5, req_data0 = 64'hDEAD -> req_ready = 01 in the same cycle. Next cycle: wr_en = 1, wr_addr = 5, wr_data = 64'hDEAD, wr_dec = 32'h00000020.
- Dual contention: req_valid = 11 held for 4 cycles (reg0 = 1, reg1 = 2) -> grants 0,1,0,1; wr_addr sequence 1,2,1,2 with wr_en continuously high; prio toggles each cycle.
- Hold: assert hold for 3 cycles mid-stream with req_valid = 11 -> req_ready = 00 and prio frozen. wr_en goes low one cycle after hold rises; on release, the grant goes to the requester that held prio before the hold.
- Same register: reg0 = reg1 = 7, data0 = 1, data1 = 2, prio = 1 -> first write 7 <= 2, then 7 <= 1 on consecutive cycles.
- With ZERO_REG_SUPPRESS_EN: req_reg0 = 31 -> req_ready[0] = 1, next cycle wr_en = 0 and wr_dec = 0. Without the macro: wr_en = 1 and wr_dec = 32'h80000000.
